pix_tx_fifo: RTL and testbench

//  Elastic output buffer between the convolutor result stream and the UART transmitter.

---
 rtl/pix_pkg.sv | 15 +
 rtl/sdp_ram.sv | 31 +++
 rtl/pix_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_pix_tx_fifo.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pix_pkg.sv
// Shared types and default sizes for the pixel transmit buffer.
package pix_pkg;

    localparam int D_BITS_DEF = 8;
    localparam int DEPTH_DEF  = 1024;
    localparam int TOT_W_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        HOLD = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on
// storage or read data so it maps onto block RAM.
module sdp_ram
    import pix_pkg::*;
#(
    parameter int D_BITS = D_BITS_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [D_BITS-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [D_BITS-1:0] rdata
);

    logic [D_BITS-1:0] mem [DEPTH];

    // Storage write and registered read; read data only changes when re is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pix_tx_fifo.sv
// Elastic buffer between the convolutor pixel stream and the UART transmitter,
// with per-frame sent counting and an end-of-frame pulse.
module pix_tx_fifo
    import pix_pkg::*;
#(
    parameter int D_BITS = D_BITS_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int TOT_W  = TOT_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     reset,
    input  logic                     i_wr,
    input  logic [D_BITS-1:0]        i_data,
    input  logic [TOT_W-1:0]         i_tot,
    input  logic                     i_tx_rdy,
    output logic [D_BITS-1:0]        o_data,
    output logic                     o_tx_enable,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [TOT_W-1:0]         o_sent_cnt,
    output logic                     o_frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] TOT_ONE  = {{(TOT_W-1){1'b0}}, 1'b1};
    localparam logic [TOT_W-1:0] TOT_ZERO = {TOT_W{1'b0}};

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    tx_state_t          state;
    tx_state_t          state_next;
    logic               empty;
    logic               full;
    logic               wr_en;
    logic               rd_en;
    logic [D_BITS-1:0]  ram_q;
    logic [TOT_W-1:0]   sent_plus;
    logic               frame_hit;

    // Occupancy flags and port enables; a read is only launched from IDLE.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        wr_en     = i_wr & ~full;
        rd_en     = (state == IDLE) & ~empty & i_tx_rdy;
        sent_plus = o_sent_cnt + TOT_ONE;
        frame_hit = (i_tot != TOT_ZERO) && (sent_plus == i_tot);
    end

    assign o_empty = empty;
    assign o_full  = full;
    assign o_count = wr_ptr - rd_ptr;

    sdp_ram #(
        .D_BITS (D_BITS),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (i_data),
        .re    (rd_en),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_q)
    );

    // Buffer pointers and the sticky overflow flag.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= {(AW+1){1'b0}};
            rd_ptr     <= {(AW+1){1'b0}};
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (i_wr && full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Drain FSM state register.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain FSM next state: IDLE waits for data and an idle transmitter, the
    // rest of the sequence is fixed length; HOLD covers the transmitter's
    // one-cycle delay in dropping its ready flag.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rd_en) begin
                    state_next = READ;
                end else begin
                    state_next = IDLE;
                end
            end
            READ:    state_next = SEND;
            SEND:    state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered transmit outputs and frame accounting.
    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            o_data       <= {D_BITS{1'b0}};
            o_tx_enable  <= 1'b0;
            o_sent_cnt   <= TOT_ZERO;
            o_frame_done <= 1'b0;
        end else begin
            o_tx_enable  <= (state == READ);
            o_frame_done <= 1'b0;
            if (state == READ) begin
                o_data <= ram_q;
            end
            if (state == SEND) begin
                if (frame_hit) begin
                    o_sent_cnt   <= TOT_ZERO;
                    o_frame_done <= 1'b1;
                end else begin
                    o_sent_cnt   <= sent_plus;
                end
            end
        end
    end

endmodule

// File: tb/tb_pix_tx_fifo.sv
// Scoreboard bench for pix_tx_fifo (DEPTH=4): expected bytes are queued when
// written and compared against bytes captured on each transmit pulse.
module tb_pix_tx_fifo;

    localparam int D_BITS = 8;
    localparam int DEPTH  = 4;
    localparam int TOT_W  = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_wr = 1'b0;
    logic [7:0]        i_data = 8'h00;
    logic [31:0]       i_tot = 32'd0;
    logic              i_tx_rdy = 1'b0;
    logic [7:0]        o_data;
    logic              o_tx_enable;
    logic              o_empty;
    logic              o_full;
    logic [2:0]        o_count;
    logic              o_overflow;
    logic [31:0]       o_sent_cnt;
    logic              o_frame_done;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          tx_total = 0;
    int          last_tx = 0;
    int          busy = 0;
    bit          uart_auto = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  obs_q[$];
    int          obs_t[$];
    int          fd_q[$];
    int          fd_gap[$];

    pix_tx_fifo #(.D_BITS(D_BITS), .DEPTH(DEPTH), .TOT_W(TOT_W)) dut (
        .i_clk        (clk),
        .reset        (reset),
        .i_wr         (i_wr),
        .i_data       (i_data),
        .i_tot        (i_tot),
        .i_tx_rdy     (i_tx_rdy),
        .o_data       (o_data),
        .o_tx_enable  (o_tx_enable),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_sent_cnt   (o_sent_cnt),
        .o_frame_done (o_frame_done)
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge, capture transmit/frame events and run
    // the UART model (busy for 10 cycles after each start pulse).
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (o_tx_enable) begin
            obs_q.push_back(o_data);
            obs_t.push_back(cyc);
            tx_total++;
            last_tx = cyc;
        end
        if (o_frame_done) begin
            fd_q.push_back(tx_total);
            fd_gap.push_back(cyc - last_tx);
        end
        if (!uart_auto) begin
            busy = 0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) i_tx_rdy = 1'b1;
        end else if (o_tx_enable) begin
            i_tx_rdy = 1'b0;
            busy = 10;
        end
    endtask

    task automatic do_reset();
        i_wr = 1'b0;
        uart_auto = 1'b0;
        i_tx_rdy = 1'b0;
        i_tot = 32'd0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
        fd_q.delete();
        fd_gap.delete();
        tx_total = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", o_count); end
        n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", o_full); end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
        n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %0h expected 0", o_data); end
        n_cmp++; if (o_sent_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_sent: got %0d expected 0", o_sent_cnt); end
        n_cmp++; if ({o_tx_enable, o_frame_done} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b expected 00", {o_tx_enable, o_frame_done}); end
        i_tx_rdy = 1'b1;
        repeat (20) tick();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL reset_quiet: got %0d pulses expected 0", obs_q.size()); end
    endtask

    task automatic test_single();
        logic [7:0] got;
        do_reset();
        i_tx_rdy = 1'b1;
        tick();
        i_wr = 1'b1; i_data = 8'hA5; exp_q.push_back(8'hA5);
        tick();
        i_wr = 1'b0;
        n_cmp++; if (o_count !== 3'd1) begin n_bad++; $display("FAIL single_count_t: got %0d expected 1", o_count); end
        n_cmp++; if (o_tx_enable !== 1'b0) begin n_bad++; $display("FAIL single_en_t: got %b expected 0", o_tx_enable); end
        tick();
        n_cmp++; if (o_tx_enable !== 1'b0) begin n_bad++; $display("FAIL single_en_t1: got %b expected 0", o_tx_enable); end
        n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL single_count_t1: got %0d expected 0", o_count); end
        tick();
        n_cmp++; if (o_tx_enable !== 1'b1) begin n_bad++; $display("FAIL single_en_t2: got %b expected 1", o_tx_enable); end
        if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 8'hxx;
        n_cmp++; if (got !== exp_q.pop_front()) begin n_bad++; $display("FAIL single_data: got %0h expected a5", got); end
        repeat (6) tick();
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL single_extra: got %0d pulses expected 0", obs_q.size()); end
        n_cmp++; if (o_sent_cnt !== 32'd1) begin n_bad++; $display("FAIL single_sent: got %0d expected 1", o_sent_cnt); end
    endtask

    task automatic test_burst();
        logic [7:0] got;
        logic [7:0] want;
        do_reset();
        uart_auto = 1'b1;
        i_tx_rdy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            i_wr = 1'b1; i_data = 8'(i); exp_q.push_back(8'(i));
            tick();
        end
        i_wr = 1'b0;
        for (int k = 0; k < 300 && obs_q.size() < 5; k++) tick();
        n_cmp++; if (obs_q.size() != 5) begin n_bad++; $display("FAIL burst_num: got %0d expected 5", obs_q.size()); end
        for (int i = 1; i < obs_t.size(); i++) begin
            n_cmp++;
            if (obs_t[i] - obs_t[i-1] < 12) begin n_bad++; $display("FAIL burst_spacing: got %0d cycles expected >=12", obs_t[i] - obs_t[i-1]); end
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 8'hxx;
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL burst_data: got %0h expected %0h", got, want); end
        end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL burst_overflow: got %b expected 0", o_overflow); end
    endtask

    task automatic test_overflow();
        logic [7:0] got;
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            i_wr = 1'b1; i_data = 8'h10 + 8'(i);
            if (i < 4) exp_q.push_back(8'h10 + 8'(i));
            tick();
            if (i == 2) begin
                n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL ovf_full_early: got %b expected 0", o_full); end
            end
            if (i == 3) begin
                n_cmp++; if (o_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full_4th: got %b expected 1", o_full); end
                n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_flag_early: got %b expected 0", o_overflow); end
            end
        end
        i_wr = 1'b0;
        tick();
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b expected 1", o_overflow); end
        n_cmp++; if (o_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d expected 4", o_count); end
        uart_auto = 1'b1;
        i_tx_rdy = 1'b1;
        repeat (100) tick();
        n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL ovf_num: got %0d expected 4", obs_q.size()); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 8'hxx;
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL ovf_data: got %0h expected %0h", got, want); end
        end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL ovf_drained: got %b expected 1", o_empty); end
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b expected 1", o_overflow); end
    endtask

    task automatic test_frame();
        logic [7:0] got;
        logic [7:0] want;
        do_reset();
        i_tot = 32'd3;
        uart_auto = 1'b1;
        i_tx_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            i_wr = 1'b1; i_data = 8'h40 + 8'(i); exp_q.push_back(8'h40 + 8'(i));
            tick();
            i_wr = 1'b0;
            repeat (15) tick();
        end
        repeat (20) tick();
        n_cmp++; if (obs_q.size() != 7) begin n_bad++; $display("FAIL frame_num: got %0d expected 7", obs_q.size()); end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 8'hxx;
            n_cmp++; if (got !== want) begin n_bad++; $display("FAIL frame_data: got %0h expected %0h", got, want); end
        end
        n_cmp++; if (fd_q.size() != 2) begin n_bad++; $display("FAIL frame_pulses: got %0d expected 2", fd_q.size()); end
        for (int i = 0; i < fd_q.size(); i++) begin
            n_cmp++; if (fd_q[i] != 3 * (i + 1)) begin n_bad++; $display("FAIL frame_pos: got after pulse %0d expected %0d", fd_q[i], 3 * (i + 1)); end
            n_cmp++; if (fd_gap[i] != 1) begin n_bad++; $display("FAIL frame_gap: got %0d expected 1", fd_gap[i]); end
        end
        n_cmp++; if (o_sent_cnt !== 32'd1) begin n_bad++; $display("FAIL frame_sent: got %0d expected 1", o_sent_cnt); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        bit seen;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            i_wr = 1'b1; i_data = 8'h50 + 8'(i);
            tick();
        end
        i_wr = 1'b0;
        i_tx_rdy = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = o_tx_enable;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mid_send_seen: got %b expected 1", seen); end
        n_cmp++; if (o_count !== 3'd3) begin n_bad++; $display("FAIL mid_queued: got %0d expected 3", o_count); end
        reset = 1'b1;
        #1;
        n_cmp++; if (o_tx_enable !== 1'b0) begin n_bad++; $display("FAIL mid_en_drop: got %b expected 0", o_tx_enable); end
        n_cmp++; if (o_empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty: got %b expected 1", o_empty); end
        do_reset();
        uart_auto = 1'b1;
        i_tx_rdy = 1'b1;
        i_wr = 1'b1; i_data = 8'h3C; exp_q.push_back(8'h3C);
        tick();
        i_wr = 1'b0;
        repeat (30) tick();
        n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL mid_num: got %0d expected 1", obs_q.size()); end
        if (obs_q.size() > 0) got = obs_q.pop_front(); else got = 8'hxx;
        n_cmp++; if (got !== exp_q.pop_front()) begin n_bad++; $display("FAIL mid_data: got %0h expected 3c", got); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_frame();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
